// File: rtl/banco_reg_dst_if.sv
// ---------------------------------------------------------------------------
// banco_reg_dst_if
// Bus between the multicycle datapath and the 32 x 32-bit register bank.
//
// Signals:
//   reg_write   write enable, sampled on the rising clock edge
//   write_reg   destination index from the register-destination select stage
//   write_data  data to store
//   read_reg1   read port 1 index (rs)
//   read_reg2   read port 2 index (rt)
//   read_data1  read port 1 data (combinational)
//   read_data2  read port 2 data (combinational)
//   sp_out      stored value of register 29
//   ra_out      stored value of register 31
//
// Modports:
//   master  datapath side (drives indices, write enable and data)
//   slave   register bank side (returns read data and monitor values)
// ---------------------------------------------------------------------------
interface banco_reg_dst_if;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic [31:0] sp_out;
  logic [31:0] ra_out;

  modport master (
    output reg_write,
    output write_reg,
    output write_data,
    output read_reg1,
    output read_reg2,
    input  read_data1,
    input  read_data2,
    input  sp_out,
    input  ra_out
  );

  modport slave (
    input  reg_write,
    input  write_reg,
    input  write_data,
    input  read_reg1,
    input  read_reg2,
    output read_data1,
    output read_data2,
    output sp_out,
    output ra_out
  );
endinterface

// File: rtl/banco_reg_dst.sv
// ---------------------------------------------------------------------------
// banco_reg_dst
// 32 x 32-bit general-purpose register bank for the multicycle datapath.
// Register 0 is hard-wired to zero, register 29 ($sp) and register 31 ($ra)
// have their own reset values. Two independent combinational read ports feed
// the A/B operand latches; an optional bypass forwards the word being written
// in the current cycle to a read port that addresses the same register.
//
// Parameters:
//   SP_RESET  reset value of register 29
//   RA_RESET  reset value of register 31
//   BYPASS    1: a read of the register being written returns write_data
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    banco_reg_dst_if.slave (write port, two read ports, monitors)
// ---------------------------------------------------------------------------
module banco_reg_dst #(
  parameter logic [31:0] SP_RESET = 32'd227,
  parameter logic [31:0] RA_RESET = 32'd0,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  banco_reg_dst_if.slave  bus
);

  localparam int DATA_W = 32;
  localparam int NREGS  = 32;
  localparam logic [4:0] SP_IDX = 5'd29;
  localparam logic [4:0] RA_IDX = 5'd31;

  logic [DATA_W-1:0] r [NREGS];

  // Write to index 0 is dropped here so r[0] never leaves its reset value.
  logic wr_en;
  assign wr_en = bus.reg_write && (bus.write_reg != 5'd0);

  // Forwarding is only legal outside reset: while reset is low the bank is
  // pinned to its reset contents and the pending write will be lost.
  logic fwd_en;
  assign fwd_en = BYPASS && reset && wr_en;

  // Reset value of one storage word.
  function automatic logic [DATA_W-1:0] reset_word(input int idx);
    if (idx == int'(SP_IDX))      reset_word = SP_RESET;
    else if (idx == int'(RA_IDX)) reset_word = RA_RESET;
    else                          reset_word = '0;
  endfunction

  // One read port: index 0 reads zero, a matching in-flight write wins when
  // forwarding is enabled, otherwise the stored word.
  function automatic logic [DATA_W-1:0] read_port(
    input logic [4:0]        idx,
    input logic [DATA_W-1:0] stored,
    input logic              fwd,
    input logic [4:0]        widx,
    input logic [DATA_W-1:0] wdata
  );
    if (idx == 5'd0)                read_port = '0;
    else if (fwd && (idx == widx))  read_port = wdata;
    else                            read_port = stored;
  endfunction

  // Storage: asynchronous reset is dominant, so a write pending in the same
  // cycle as a reset assertion never reaches the array.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r[i] <= reset_word(i);
      end
    end else if (wr_en) begin
      r[bus.write_reg] <= bus.write_data;
    end
  end

  always_comb begin
    bus.read_data1 = read_port(bus.read_reg1, r[bus.read_reg1], fwd_en,
                               bus.write_reg, bus.write_data);
    bus.read_data2 = read_port(bus.read_reg2, r[bus.read_reg2], fwd_en,
                               bus.write_reg, bus.write_data);
  end

  // Monitors always show architectural state, never the forwarded word.
  assign bus.sp_out = r[SP_IDX];
  assign bus.ra_out = r[RA_IDX];

endmodule

// File: doc/banco_reg_dst.md
Name: banco_reg_dst

Overview:
- 32 x 32-bit general-purpose register bank.
- Consumes the write-register index chosen by the register-destination select stage:
  - rt or rd field
  - 29 ($sp)
  - 31 ($ra)
  - shift-amount-derived index
- Provides two combinational read ports to the A/B operand latches of the multicycle datapath.
- Owns the architectural reset state of $zero, $sp and $ra.

Parameters:
- SP_RESET, 32'd227, reset value of register 29 (stack pointer).
- RA_RESET, 32'd0, reset value of register 31 (return address).
- BYPASS, 1, when 1 a read of the register being written this cycle returns write_data.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- reg_write  input  1  write enable, sampled on rising clk.
- write_reg  input  5  destination index; driven from bits [4:0] of the register-destination select output.
- write_data  input  32  data to store.
- read_reg1  input  5  read port 1 index (rs).
- read_reg2  input  5  read port 2 index (rt).
- read_data1  output  32  read port 1 data.
- read_data2  output  32  read port 2 data.
- sp_out  output  32  current value of register 29 (debug/monitor).
- ra_out  output  32  current value of register 31 (debug/monitor).

Behaviour:
- Storage: 32 flip-flop words, r[0..31].
- Reset (reset=0, asynchronous, dominant over clk):
  - r[29]=SP_RESET, r[31]=RA_RESET, all other words 0.
  - Outputs follow combinationally: read_data1/2 reflect the reset contents of the addressed registers, sp_out=SP_RESET, ra_out=RA_RESET.
- Reset release is asynchronous. The first write can occur on the first rising edge with reset=1.
- Write: on rising clk with reset=1 and reg_write=1, r[write_reg] <= write_data.
  - One-cycle latency to architectural state.
  - write_reg=0: write discarded, r[0] stays 0.
  - reg_write=0: no register changes, regardless of write_reg/write_data.
- Read, combinational, no clock:
  - read_dataN = 0 when read_regN=0.
  - Otherwise read_dataN = r[read_regN].
- Bypass when BYPASS=1 and reset=1:
  - If reg_write=1, write_reg!=0 and read_regN==write_reg, then read_dataN=write_data in the same cycle, before the edge.
  - With BYPASS=0, read_dataN shows the old value until the edge.
- Both read ports are independent:
  - Identical indices give identical data.
  - Both ports may bypass simultaneously.
- sp_out and ra_out always show the stored r[29] and r[31]. They are never bypassed.
- Reset asserted mid-cycle while reg_write=1: the write is lost and reset values hold. No partial update.
- Out-of-range indices cannot occur: all indices are 5-bit, and the upper bits of the select-stage output are ignored by construction.
- No X propagation: all storage is defined after reset.

Test Plan:
1. Assert reset=0 for 2 cycles, release. Then:
   - read_reg1=29 -> read_data1=227.
   - read_reg2=31 -> read_data2=0.
   - sp_out=227.
   - Every other index reads 0.
2. reg_write=1, write_reg=5, write_data=32'hDEADBEEF, one edge; then reg_write=0, read_reg1=5. Required:
   - read_data1=DEADBEEF.
   - With BYPASS=1: read_data1=DEADBEEF during the write cycle itself.
   - With BYPASS=0: read_data1=0 during the write cycle.
3. reg_write=1, write_reg=0, write_data=32'hFFFFFFFF, then read_reg1=read_reg2=0 -> both read 0, with and without bypass.
4. Emulate a jal-style write:
   - reg_write=1, write_reg=31, write_data=32'h00000040 -> ra_out=40 after the edge.
   - Then write_reg=29, write_data=223 -> sp_out=223; r[31] still 40.
5. Back-to-back writes to the same register on consecutive edges, 1 then 2 -> value 2; both reads of that index agree.
6. Write r[7]=32'h12345678. Then assert reset asynchronously between edges while reg_write=1, write_reg=7 -> r[7] reads 0 immediately (no clock edge needed) and stays 0 after release until the next enabled write.
